// File: rtl/intt2_gs_if.sv
// Butterfly data bus: one (xin, yin, wr) triple per cycle qualified by en,
// and the matching (xout, yout) result qualified by valid.
//   master: drives xin/yin/wr/en, receives xout/yout/valid
//   slave : the butterfly pipeline
interface intt2_gs_if #(
  parameter int DW = 33
);
  logic [DW-1:0] xin;
  logic [DW-1:0] yin;
  logic [DW-1:0] wr;
  logic          en;
  logic [DW-1:0] xout;
  logic [DW-1:0] yout;
  logic          valid;

  modport master (output xin, yin, wr, en, input xout, yout, valid);
  modport slave  (input xin, yin, wr, en, output xout, yout, valid);
endinterface

// File: rtl/intt2_gs_pipeline.sv
// Gentleman-Sande inverse radix-2 butterfly over p = 2^33 - 2^20 + 1.
//   xout = (x + y) * s mod p,  yout = (x - y) * wr * s mod p,
//   s = 2^-1 when HALVE = 1, else 1. Six-cycle latency, one pair per clock.
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset, clears every pipeline register
//   bus   intt2_gs_if slave: xin/yin/wr/en in, xout/yout/valid out
module intt2_gs_pipeline #(
  parameter int          DW    = 33,
  parameter logic [32:0] P     = 33'h1_FFF0_0001,
  parameter bit          HALVE = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  intt2_gs_if.slave bus
);
  localparam int LAT = 6;

  // (v * 2^-1) mod p: odd values become even by adding p, then shift.
  function automatic logic [32:0] halve_mod(input logic [32:0] v);
    return 33'((34'(v) + (v[0] ? 34'(P) : 34'd0)) >> 1);
  endfunction

  logic [33:0] add_s;
  logic [32:0] sum_n, diff_n;
  logic [53:0] q_n;
  logic [41:0] q2;
  logic [33:0] q3;
  logic [32:0] red_n;

  logic [32:0] sum_1, diff_1, wr_1;
  logic [49:0] pp_lo_2;
  logic [48:0] pp_hi_2;
  logic [32:0] sum_2;
  logic [65:0] prod_3;
  logic [32:0] sum_3;
  logic [53:0] q_4;
  logic [32:0] sum_4;
  logic [32:0] sum_5, red_5;
  logic [32:0] x_6, y_6;
  logic [LAT-1:0] vpipe;

  always_comb begin
    add_s  = 34'(bus.xin) + 34'(bus.yin);
    sum_n  = (add_s >= 34'(P)) ? 33'(add_s - 34'(P)) : add_s[32:0];
    diff_n = (bus.xin >= bus.yin) ? 33'(bus.xin - bus.yin)
                                  : 33'(34'(bus.xin) + 34'(P) - 34'(bus.yin));
    // Folds use 2^33 == 2^20 - 1 (mod p). Three folds shrink the 66-bit
    // product below 2p, so a single conditional subtract finishes it.
    q_n   = (54'(prod_3[65:33]) << 20) - 54'(prod_3[65:33]) + 54'(prod_3[32:0]);
    q2    = (42'(q_4[53:33]) << 20) - 42'(q_4[53:33]) + 42'(q_4[32:0]);
    q3    = (34'(q2[41:33]) << 20) - 34'(q2[41:33]) + 34'(q2[32:0]);
    red_n = (q3 >= 34'(P)) ? 33'(q3 - 34'(P)) : q3[32:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_1   <= '0;
      diff_1  <= '0;
      wr_1    <= '0;
      pp_lo_2 <= '0;
      pp_hi_2 <= '0;
      sum_2   <= '0;
      prod_3  <= '0;
      sum_3   <= '0;
      q_4     <= '0;
      sum_4   <= '0;
      sum_5   <= '0;
      red_5   <= '0;
      x_6     <= '0;
      y_6     <= '0;
      vpipe   <= '0;
    end else begin
      sum_1   <= sum_n;
      diff_1  <= diff_n;
      wr_1    <= 33'(bus.wr);
      // Product split on wr[16:0] / wr[32:17], recombined next stage.
      pp_lo_2 <= 50'(diff_1) * 50'(wr_1[16:0]);
      pp_hi_2 <= 49'(diff_1) * 49'(wr_1[32:17]);
      sum_2   <= sum_1;
      prod_3  <= 66'(pp_lo_2) + (66'(pp_hi_2) << 17);
      sum_3   <= sum_2;
      q_4     <= q_n;
      sum_4   <= sum_3;
      red_5   <= red_n;
      sum_5   <= sum_4;
      x_6     <= HALVE ? halve_mod(sum_5) : sum_5;
      y_6     <= HALVE ? halve_mod(red_5) : red_5;
      vpipe   <= {vpipe[LAT-2:0], bus.en};
    end
  end

  assign bus.xout  = DW'(x_6);
  assign bus.yout  = DW'(y_6);
  assign bus.valid = vpipe[LAT-1];
endmodule
